in12_scan_driver: RTL and testbench



---
 rtl/in12_scan_driver.sv | 187 ++++++++++++++++++
 tb/tb_in12_scan_driver.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/in12_scan_driver.sv
// IN-12 nixie scan driver: snapshots a packed BCD bus once per frame and
// multiplexes it over one-hot anodes with a dark blanking gap before each digit.
module in12_scan_driver #(
    parameter int unsigned DIGITS      = 8,
    parameter int unsigned DWELL       = 1000,
    parameter int unsigned BLANK       = 50,
    parameter int unsigned LZ_SUPPRESS = 1
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Enable,
    input  logic [4*DIGITS-1:0]   Digits,
    output logic [DIGITS-1:0]     Anodes,
    output logic [3:0]            Cathode,
    output logic                  FrameStart
);

    localparam int unsigned TMAX  = (BLANK > DWELL) ? BLANK : DWELL;
    localparam int unsigned TMR_W = $clog2(TMAX + 1);
    localparam int unsigned IDX_W = $clog2(DIGITS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_ON    = 2'd2;

    localparam logic [3:0]        CATH_OFF   = 4'hA;
    localparam logic [DIGITS-1:0] ANODE_LSB  = {{(DIGITS-1){1'b0}}, 1'b1};
    localparam logic [TMR_W-1:0]  BLANK_LAST = TMR_W'(BLANK - 1);
    localparam logic [TMR_W-1:0]  DWELL_LAST = TMR_W'(DWELL - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);

    logic [1:0]            r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [TMR_W-1:0]      r_timer;
    logic [4*DIGITS-1:0]   r_snap;
    logic [DIGITS-1:0]     r_lz;
    logic [DIGITS-1:0]     r_anodes;
    logic [3:0]            r_cathode;
    logic                  r_frame_start;

    logic [1:0]            w_state_nxt;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [TMR_W-1:0]      w_timer_nxt;
    logic [4*DIGITS-1:0]   w_snap_nxt;
    logic [DIGITS-1:0]     w_lz_nxt;
    logic [DIGITS-1:0]     w_anodes_nxt;
    logic [3:0]            w_cathode_nxt;
    logic                  w_frame_start_nxt;
    logic [IDX_W-1:0]      w_idx_inc;
    logic [IDX_W+1:0]      w_inc_base;

    // BCD to physical IN-12 pin; suppressed or non-BCD values turn the tube off
    function automatic logic [3:0] pin_code(input logic [3:0] bcd, input logic sup);
        logic [3:0] code;
        case (bcd)
            4'd0:    code = 4'd1;
            4'd1:    code = 4'd0;
            4'd2:    code = 4'd2;
            4'd3:    code = 4'd3;
            4'd4:    code = 4'd6;
            4'd5:    code = 4'd8;
            4'd6:    code = 4'd9;
            4'd7:    code = 4'd7;
            4'd8:    code = 4'd5;
            4'd9:    code = 4'd4;
            default: code = CATH_OFF;
        endcase
        return sup ? CATH_OFF : code;
    endfunction

    // Digit i is suppressed when it and every digit above it are zero; digit 0 never is
    function automatic logic [DIGITS-1:0] lz_mask(input logic [4*DIGITS-1:0] d);
        logic [DIGITS-1:0] mask;
        logic              zero_above;
        mask       = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (d[4*i +: 4] == 4'd0);
            mask[i]    = (LZ_SUPPRESS != 0) && zero_above;
        end
        return mask;
    endfunction

    assign w_idx_inc  = r_idx + IDX_W'(1);
    assign w_inc_base = {w_idx_inc, 2'b00};

    // State and output registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_timer       <= '0;
            r_snap        <= '0;
            r_lz          <= '0;
            r_anodes      <= '0;
            r_cathode     <= CATH_OFF;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_timer       <= w_timer_nxt;
            r_snap        <= w_snap_nxt;
            r_lz          <= w_lz_nxt;
            r_anodes      <= w_anodes_nxt;
            r_cathode     <= w_cathode_nxt;
            r_frame_start <= w_frame_start_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt       = r_state;
        w_idx_nxt         = r_idx;
        w_timer_nxt       = r_timer;
        w_snap_nxt        = r_snap;
        w_lz_nxt          = r_lz;
        w_anodes_nxt      = r_anodes;
        w_cathode_nxt     = r_cathode;
        w_frame_start_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_anodes_nxt  = '0;
                w_cathode_nxt = CATH_OFF;
                w_timer_nxt   = '0;
                if (Enable) begin
                    w_state_nxt       = S_BLANK;
                    w_idx_nxt         = '0;
                    w_snap_nxt        = Digits;
                    w_lz_nxt          = lz_mask(Digits);
                    w_cathode_nxt     = pin_code(Digits[3:0], 1'b0);
                    w_frame_start_nxt = 1'b1;
                end
            end
            S_BLANK: begin
                if (!Enable) begin
                    w_state_nxt   = S_IDLE;
                    w_timer_nxt   = '0;
                    w_anodes_nxt  = '0;
                    w_cathode_nxt = CATH_OFF;
                end else if (r_timer == BLANK_LAST) begin
                    // Cathode was precharged; an off code means this slot stays dark
                    w_state_nxt  = S_ON;
                    w_timer_nxt  = '0;
                    w_anodes_nxt = (r_cathode == CATH_OFF) ? '0 : (ANODE_LSB << r_idx);
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            S_ON: begin
                if (!Enable) begin
                    w_state_nxt   = S_IDLE;
                    w_timer_nxt   = '0;
                    w_anodes_nxt  = '0;
                    w_cathode_nxt = CATH_OFF;
                end else if (r_timer == DWELL_LAST) begin
                    w_state_nxt  = S_BLANK;
                    w_timer_nxt  = '0;
                    w_anodes_nxt = '0;
                    if (r_idx == IDX_LAST) begin
                        w_idx_nxt         = '0;
                        w_snap_nxt        = Digits;
                        w_lz_nxt          = lz_mask(Digits);
                        w_cathode_nxt     = pin_code(Digits[3:0], 1'b0);
                        w_frame_start_nxt = 1'b1;
                    end else begin
                        w_idx_nxt     = w_idx_inc;
                        w_cathode_nxt = pin_code(r_snap[w_inc_base +: 4], r_lz[w_idx_inc]);
                    end
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_timer_nxt   = '0;
                w_anodes_nxt  = '0;
                w_cathode_nxt = CATH_OFF;
            end
        endcase
    end

    assign Anodes     = r_anodes;
    assign Cathode    = r_cathode;
    assign FrameStart = r_frame_start;

endmodule

// File: tb/tb_in12_scan_driver.sv
// Self-checking bench for in12_scan_driver: directed scenarios plus random
// Enable/Digits traffic, compared each cycle against a frame-position model.
module tb_in12_scan_driver;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned DWELL  = 4;
    localparam int unsigned BLANK  = 2;
    localparam int unsigned SLOT   = BLANK + DWELL;
    localparam int unsigned FRAME  = DIGITS * SLOT;

    logic        Clk    = 1'b0;
    logic        Rst_n  = 1'b0;
    logic        Enable = 1'b0;
    logic [15:0] Digits = 16'h0;
    logic [3:0]  Anodes;
    logic [3:0]  Cathode;
    logic        FrameStart;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Model: active flag, position within the frame, and the frame's snapshot
    bit          m_act = 1'b0;
    int          m_p   = 0;
    logic [15:0] m_snap = 16'h0;

    always #5 Clk = ~Clk;

    in12_scan_driver #(
        .DIGITS(DIGITS), .DWELL(DWELL), .BLANK(BLANK), .LZ_SUPPRESS(1)
    ) u_dut (
        .Clk(Clk), .Rst_n(Rst_n), .Enable(Enable), .Digits(Digits),
        .Anodes(Anodes), .Cathode(Cathode), .FrameStart(FrameStart)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t p=%0d)", tag, got, exp, $time, m_p);
        end
    endtask

    function automatic logic [3:0] exp_cathode();
        logic [3:0] pin_tab [10] = '{4'd1, 4'd0, 4'd2, 4'd3, 4'd6, 4'd8, 4'd9, 4'd7, 4'd5, 4'd4};
        int         slot;
        logic [3:0] nib;
        if (!m_act) return 4'hA;
        slot = m_p / SLOT;
        nib  = m_snap[4*slot +: 4];
        if (slot > 0 && (m_snap >> (4*slot)) == 16'h0) return 4'hA;
        if (nib > 4'd9) return 4'hA;
        return pin_tab[nib];
    endfunction

    function automatic logic [3:0] exp_anodes();
        int slot;
        if (!m_act) return 4'h0;
        slot = m_p / SLOT;
        if ((m_p % SLOT) >= BLANK && exp_cathode() != 4'hA) return 4'(1 << slot);
        return 4'h0;
    endfunction

    task automatic step();
        @(posedge Clk);
        if (!m_act) begin
            if (Enable) begin
                m_act  = 1'b1;
                m_p    = 0;
                m_snap = Digits;
            end
        end else if (!Enable) begin
            m_act = 1'b0;
        end else begin
            m_p++;
            if (m_p == FRAME) begin
                m_p    = 0;
                m_snap = Digits;
            end
        end
        #1;
        check("anodes",     32'(Anodes),     32'(exp_anodes()));
        check("cathode",    32'(Cathode),    32'(exp_cathode()));
        check("framestart", 32'(FrameStart), 32'(m_act && m_p == 0));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until(input int target);
        bit hit = 1'b0;
        for (int i = 0; i < 4 * FRAME && !hit; i++) begin
            if (m_act && m_p == target) hit = 1'b1;
            else step();
        end
        if (!hit) check("reach_position", 32'(m_p), 32'(target));
    endtask

    function automatic logic [15:0] rand_digits();
        logic [15:0] d;
        int          r;
        for (int i = 0; i < 4; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4)       d[4*i +: 4] = 4'd0;
            else if (r == 9) d[4*i +: 4] = 4'($urandom_range(10, 15));
            else             d[4*i +: 4] = 4'($urandom_range(1, 9));
        end
        return d;
    endfunction

    initial begin
        // Reset held with random inputs
        Enable = 1'($urandom_range(0, 1));
        Digits = 16'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk);
            #1;
            check("rst_anodes",  32'(Anodes),     32'h0);
            check("rst_cathode", 32'(Cathode),    32'hA);
            check("rst_fs",      32'(FrameStart), 32'h0);
        end
        Rst_n  = 1'b1;
        m_act  = 1'b0;

        // Basic scan, then mid-frame change during digit 1 ON
        Digits = 16'h1234;
        Enable = 1'b1;
        run(FRAME + 2);
        run_until(SLOT + BLANK + 1);
        Digits = 16'h5678;
        run(2 * FRAME);

        // Leading-zero suppression and invalid digit
        Digits = 16'h0070;
        run(2 * FRAME);
        Digits = 16'h0000;
        run(2 * FRAME);
        Digits = 16'h1C34;
        run(2 * FRAME);

        // Enable drop during digit 2 ON, then re-enable
        Digits = 16'h1234;
        run(FRAME);
        run_until(2 * SLOT + BLANK + 1);
        Enable = 1'b0;
        step();
        Enable = 1'b1;
        run(FRAME + 3);

        // Asynchronous reset while digit 0 is lit
        run_until(BLANK + 1);
        @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        check("async_anodes",  32'(Anodes),  32'h0);
        check("async_cathode", 32'(Cathode), 32'hA);
        m_act = 1'b0;
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        run(FRAME + 2);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            Enable = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 14) == 0) Digits = rand_digits();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
